// File: rtl/cache_data_pkg.sv
// Shared widths, default geometry and FSM state type for the L1 data-array controller.
// Derived widths are helper functions, so any parameterisation of the top can reuse them.
package cache_data_pkg;

   localparam int DEF_WAYS        = 4;
   localparam int DEF_BANKS       = 2;
   localparam int DEF_BANK_BYTES  = 4;
   localparam int DEF_ADDR_BITS   = 12;
   localparam int DEF_OFFSET_BITS = 3;

   function automatic int calc_row_bits(input int addr_bits, input int offset_bits);
      return addr_bits - offset_bits;
   endfunction

   function automatic int calc_bank_w(input int bank_bytes);
      return bank_bytes * 8;
   endfunction

   function automatic int calc_way_w(input int banks, input int bank_bytes);
      return banks * bank_bytes * 8;
   endfunction

   // Widths for the default geometry.
   localparam int ROW_BITS = calc_row_bits(DEF_ADDR_BITS, DEF_OFFSET_BITS);
   localparam int BANK_W   = calc_bank_w(DEF_BANK_BYTES);
   localparam int WAY_W    = calc_way_w(DEF_BANKS, DEF_BANK_BYTES);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/cache_data_bank_sram.sv
// One data bank: ROWS x LANES bytes, byte-enabled single-port synchronous RAM.
// Read data appears one cycle after an enabled read and holds until the next read.
module cache_data_bank_sram #(
   parameter int ROWS     = 512,
   parameter int ROW_BITS = 9,
   parameter int LANES    = 16
) (
   input  logic                  clock,
   input  logic                  en,
   input  logic                  we,
   input  logic [ROW_BITS-1:0]   addr,
   input  logic [LANES-1:0]      wbe,
   input  logic [LANES*8-1:0]    wdata,
   output logic [LANES*8-1:0]    rdata
);

   logic [LANES-1:0][7:0] mem_q [ROWS];
   logic [LANES*8-1:0]    rdata_q;

   // NOTE: the storage array has no reset; clearing it is the controller's INIT sweep,
   // and a reset port here would stop the array mapping onto an SRAM macro.
   always_ff @(posedge clock) begin
      if (en) begin
         if (we) begin
            for (int j = 0; j < LANES; j++) begin
               if (wbe[j]) begin
                  mem_q[addr][j] <= wdata[j*8 +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/cache_data_array_ctl.sv
// L1 data-array controller: valid/ready request port, zero-init FSM, per-bank SRAMs,
// read pipeline with optional output register and a response held until the next one.
module cache_data_array_ctl
   import cache_data_pkg::*;
#(
   parameter int WAYS          = DEF_WAYS,
   parameter int BANKS         = DEF_BANKS,
   parameter int BANK_BYTES    = DEF_BANK_BYTES,
   parameter int ADDR_BITS     = DEF_ADDR_BITS,
   parameter int OFFSET_BITS   = DEF_OFFSET_BITS,
   parameter int OUT_REG       = 0,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic                                req_write,
   input  logic [ADDR_BITS-1:0]                req_addr,
   input  logic [BANKS-1:0]                    req_bank_en,
   input  logic [WAYS-1:0]                     req_way_en,
   input  logic [BANK_BYTES-1:0]               req_byte_mask,
   input  logic [BANKS*BANK_BYTES*8-1:0]       req_wdata,
   input  logic                                flush,
   output logic                                resp_valid,
   output logic [WAYS*BANKS*BANK_BYTES*8-1:0]  resp_data,
   output logic                                init_busy
);

   localparam int IDX_BITS = calc_row_bits(ADDR_BITS, OFFSET_BITS);
   localparam int ROWS     = 1 << IDX_BITS;
   localparam int BANK_DW  = calc_bank_w(BANK_BYTES);
   localparam int LANES    = WAYS * BANK_BYTES;
   localparam int RESP_W   = WAYS * calc_way_w(BANKS, BANK_BYTES);

   state_e                state_q;
   logic [IDX_BITS-1:0]   cnt_q;
   logic                  ready_q;
   logic                  busy_q;

   logic                  in_init;
   logic                  accept;
   logic [IDX_BITS-1:0]   bank_addr;
   logic                  unused_addr_bits;

   logic                  rd_vld_q;
   logic [BANKS-1:0]      rd_ben_q;
   logic [LANES*8-1:0]    bank_rdata [BANKS];
   logic [RESP_W-1:0]     rd_data;

   assign in_init          = (state_q == ST_INIT);
   assign accept           = req_valid & ready_q;
   assign bank_addr        = in_init ? cnt_q : req_addr[ADDR_BITS-1:OFFSET_BITS];
   assign unused_addr_bits = ^req_addr[OFFSET_BITS-1:0];

   assign req_ready = ready_q;
   assign init_busy = busy_q;

   // ready_q is only ever 1 in RUN, so accept never fires during the INIT sweep.
   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= (INIT_ON_RESET != 0);
      end else if (state_q == ST_INIT) begin
         if (flush) begin
            cnt_q <= '0;
         end else if (&cnt_q) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else begin
         if (flush) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
         end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic               en;
      logic               we;
      logic [LANES-1:0]   wbe;
      logic [LANES*8-1:0] wdata;

      // NOTE: every output gets a default first so no path through the block infers a latch.
      always_comb begin
         en    = 1'b0;
         we    = 1'b0;
         wbe   = '0;
         wdata = '0;
         if (in_init) begin
            en  = 1'b1;
            we  = 1'b1;
            wbe = '1;
         end else if (accept) begin
            en    = req_bank_en[b];
            we    = req_write;
            wdata = {WAYS{req_wdata[b*BANK_DW +: BANK_DW]}};
            for (int w = 0; w < WAYS; w++) begin
               for (int j = 0; j < BANK_BYTES; j++) begin
                  wbe[w*BANK_BYTES + j] = req_way_en[w] & req_byte_mask[j];
               end
            end
         end
      end

      cache_data_bank_sram #(
         .ROWS     (ROWS),
         .ROW_BITS (IDX_BITS),
         .LANES    (LANES)
      ) u_sram (
         .clock (clock),
         .en    (en),
         .we    (we),
         .addr  (bank_addr),
         .wbe   (wbe),
         .wdata (wdata),
         .rdata (bank_rdata[b])
      );
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_vld_q <= 1'b0;
         rd_ben_q <= '0;
      end else begin
         rd_vld_q <= accept & ~req_write;
         if (accept & ~req_write) begin
            rd_ben_q <= req_bank_en;
         end
      end
   end

   // Reorder bank-major SRAM words into the way-major response; disabled banks read as zero.
   always_comb begin
      rd_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         for (int b = 0; b < BANKS; b++) begin
            if (rd_ben_q[b]) begin
               rd_data[(w*BANKS + b)*BANK_DW +: BANK_DW] = bank_rdata[b][w*BANK_DW +: BANK_DW];
            end
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic              out_vld_q;
      logic [RESP_W-1:0] out_data_q;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
         end else begin
            out_vld_q <= rd_vld_q;
            if (rd_vld_q) begin
               out_data_q <= rd_data;
            end
         end
      end

      assign resp_valid = out_vld_q;
      assign resp_data  = out_data_q;
   end else begin : g_out_comb
      logic [RESP_W-1:0] hold_q;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            hold_q <= '0;
         end else if (rd_vld_q) begin
            hold_q <= rd_data;
         end
      end

      assign resp_valid = rd_vld_q;
      assign resp_data  = rd_vld_q ? rd_data : hold_q;
   end

endmodule
